cmn_arb_vr_lru_lock: RTL and testbench
======================================

CMN_ARB_VR_LRU_LOCK -- requirements
Module: cmn_arb_vr_lru_lock

Interface
REQ-001 Parameter WIDTH, default 4: number of requesting channels; legal range 2..32.
REQ-002 Parameter LOCK_EN, default 1: 1 enables multi-beat grant lock via v_last_s; 0 makes every beat arbitrate independently.
REQ-003 Parameter IDX_W, default $clog2(WIDTH): width of the grant index output.
REQ-004 Synchronous reset is active-high; the block runs on one clock.
REQ-005 clk  input  1  clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 v_vld_s  input  WIDTH  per-channel request valid.
REQ-008 v_last_s  input  WIDTH  per-channel last-beat flag; sampled only with the granted valid.
REQ-009 v_rdy_s  output  WIDTH  per-channel ready; at most one bit set.
REQ-010 vld_m  output  1  master-side valid.
REQ-011 rdy_m  input  1  master-side ready.
REQ-012 sel_oh  output  WIDTH  one-hot selected channel for the data mux; zero when no candidate exists.
REQ-013 sel_idx  output  IDX_W  binary index of sel_oh; 0 when sel_oh is zero.
REQ-014 locked  output  1  high while a multi-beat grant is held.

Function
REQ-015 The block SHALL hold an internal WIDTH x WIDTH priority matrix pri; pri[i][j]=1 means channel j beats channel i; the diagonal is don't-care and reads 0.
REQ-016 When unlocked, candidate i SHALL be v_vld_s[i] AND no j with v_vld_s[j] AND pri[i][j]; exactly one candidate exists whenever any valid is high.
REQ-017 When locked, sel_oh SHALL equal the registered lock owner, regardless of the other valids.
REQ-018 vld_m SHALL be |(v_vld_s & sel_oh), which is combinational.
REQ-019 v_rdy_s SHALL be sel_oh & v_vld_s gated by rdy_m, which is combinational, with no rdy-to-rdy register.
REQ-020 A handshake SHALL be vld_m AND rdy_m; g denotes the granted channel.
REQ-021 On a handshake that completes a transfer, the next cycle SHALL set row g to all ones except the diagonal and clear column g in every other row, so g becomes least recently used.
REQ-022 A transfer SHALL complete when LOCK_EN=0, or when v_last_s[g]=1.
REQ-023 With LOCK_EN=1, a handshake with v_last_s[g]=0 SHALL set locked and latch g as owner from the next cycle; pri SHALL be unchanged.
REQ-024 The lock SHALL clear on the cycle after the owner's handshake with v_last_s=1; pri SHALL update on that same edge.
REQ-025 While locked, an owner valid drop SHALL keep the lock: vld_m=0 and all v_rdy_s=0 until the owner reasserts.
REQ-026 rdy_m=0 SHALL change no state.
REQ-027 Without a handshake, pri, locked and owner SHALL hold.
REQ-028 Latency: the grant is decided in the same cycle as the request; pri and lock take effect one cycle after a handshake.
REQ-029 A single-beat request with last=1 arriving while unlocked SHALL never assert locked.

Reset
REQ-030 On rst=1 at a clock edge, pri[i][j] SHALL reset to 1 for j<i and 0 otherwise, so lower index has initial priority.
REQ-031 On reset, locked and owner SHALL reset to 0.
REQ-032 Reset mid-lock SHALL abandon the lock; the next cycle arbitrates from the reset matrix.
REQ-033 Reset SHALL gate no combinational output directly; v_rdy_s and vld_m follow v_vld_s and rdy_m from reset state.

Structure
REQ-034 The reset-matrix generator function and the one-hot-to-index function SHALL live in shared package cmn_arb_pkg.
REQ-035 Candidate selection SHALL be one sub-module, cmn_arb_matrix_sel, with inputs pri and vld and output onehot, reusable by other arbiters.
REQ-036 Matrix update, lock FSM (UNLOCKED, LOCKED) and output muxing SHALL stay in this module; target 150-300 lines.

Verification
REQ-037 WIDTH=4, after reset, v_vld_s=1111, rdy_m=1, last=1111, held 4 cycles -> grants 0,1,2,3 in order, one-hot each cycle.
REQ-038 v_vld_s=0110, rdy_m=0 for 3 cycles, then 1 -> sel_oh=0010 throughout; v_rdy_s=0 then 0010; pri unchanged until the handshake.
REQ-039 LOCK_EN=1, ch2 sends 3 beats (last=0,0,1) while ch0 and ch1 request -> locked high for beats 2-3, only v_rdy_s[2] asserted; the next grant goes to ch0.
REQ-040 Locked on ch1, then v_vld_s[1]=0 for 2 cycles while ch3 is valid -> vld_m=0 and v_rdy_s=0000; ch1 resumes and completes before ch3 is granted.
REQ-041 rst pulsed mid-lock on ch3 -> locked=0 next cycle; with v_vld_s=1010 the grant goes to ch1.
REQ-042 Random valids, rdy and last for 10k cycles at WIDTH=8 -> always at most one v_rdy_s bit; no valid channel starves beyond 7 completed transfers by others.

Source files
------------

// File: rtl/cmn_arb_pkg.sv
// Shared arbiter helpers: lock FSM encoding, reset priority matrix, one-hot to index.
package cmn_arb_pkg;

  localparam int MAX_W = 32;

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_e;

  // Lower index wins initially: row i has ones in every column j<i.
  function automatic logic [MAX_W-1:0][MAX_W-1:0] pri_reset(input int w);
    pri_reset = '0;
    for (int i = 0; i < MAX_W; i++)
      for (int j = 0; j < MAX_W; j++)
        if (i < w && j < i) pri_reset[i][j] = 1'b1;
  endfunction

  function automatic logic [4:0] oh2idx(input logic [MAX_W-1:0] oh);
    oh2idx = '0;
    for (int i = 0; i < MAX_W; i++)
      if (oh[i]) oh2idx = oh2idx | 5'(i);
  endfunction

endpackage

// File: rtl/cmn_arb_matrix_sel.sv
// Matrix-arbiter candidate pick: a requester wins when no valid requester beats it.
module cmn_arb_matrix_sel #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0][WIDTH-1:0] pri,
  input  logic [WIDTH-1:0]            vld,
  output logic [WIDTH-1:0]            onehot
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    assign onehot[i] = vld[i] & ~|(vld & pri[i]);
  end

endmodule

// File: rtl/cmn_arb_vr_lru_lock.sv
// Valid/ready LRU matrix arbiter with optional multi-beat grant lock.
module cmn_arb_vr_lru_lock
  import cmn_arb_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int LOCK_EN = 1,
  parameter int IDX_W   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] v_vld_s,
  input  logic [WIDTH-1:0] v_last_s,
  output logic [WIDTH-1:0] v_rdy_s,
  output logic             vld_m,
  input  logic             rdy_m,
  output logic [WIDTH-1:0] sel_oh,
  output logic [IDX_W-1:0] sel_idx,
  output logic             locked
);

  localparam logic [MAX_W-1:0][MAX_W-1:0] PRI_RST = pri_reset(WIDTH);

  logic [WIDTH-1:0][WIDTH-1:0] pri, pri_nxt;
  lock_state_e                 state, state_nxt;
  logic [WIDTH-1:0]            owner, owner_nxt, cand;
  logic                        hs, last_g, done;

  cmn_arb_matrix_sel #(.WIDTH(WIDTH)) u_sel (
    .pri    (pri),
    .vld    (v_vld_s),
    .onehot (cand)
  );

  assign locked  = (state == LOCKED);
  assign sel_oh  = locked ? owner : cand;
  assign sel_idx = IDX_W'(oh2idx(MAX_W'(sel_oh)));
  assign vld_m   = |(v_vld_s & sel_oh);
  assign v_rdy_s = sel_oh & v_vld_s & {WIDTH{rdy_m}};
  assign hs      = vld_m & rdy_m;
  assign last_g  = |(v_last_s & sel_oh);
  assign done    = hs & ((LOCK_EN == 0) | last_g);

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    case (state)
      UNLOCKED: if (hs && LOCK_EN != 0 && !last_g) begin
        state_nxt = LOCKED;
        owner_nxt = sel_oh;
      end
      LOCKED:   if (hs && last_g) state_nxt = UNLOCKED;
      default:  state_nxt = UNLOCKED;
    endcase
  end

  // Completed grant g drops to LRU: everyone beats g, g beats no one.
  always_comb begin
    pri_nxt = pri;
    if (done)
      for (int i = 0; i < WIDTH; i++)
        for (int j = 0; j < WIDTH; j++)
          if (i == j)         pri_nxt[i][j] = 1'b0;
          else if (sel_oh[i]) pri_nxt[i][j] = 1'b1;
          else if (sel_oh[j]) pri_nxt[i][j] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= UNLOCKED;
      owner <= '0;
      for (int i = 0; i < WIDTH; i++) pri[i] <= PRI_RST[i][WIDTH-1:0];
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      pri   <= pri_nxt;
    end
  end

endmodule

// File: tb/tb_cmn_arb_vr_lru_lock.sv
// Random + directed bench against an LRU-queue reference model.
module tb_cmn_arb_vr_lru_lock;

  localparam int W  = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  v_vld_s = '0, v_last_s = '0, v_rdy_s, sel_oh;
  logic          vld_m, rdy_m = 1'b0, locked;
  logic [IW-1:0] sel_idx;

  int vec_cnt = 0, err_cnt = 0;

  // model: q front = most favoured channel
  int q[$];
  bit m_locked;
  int m_owner;
  int wait_c[W];

  cmn_arb_vr_lru_lock #(.WIDTH(W), .LOCK_EN(1), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .v_vld_s(v_vld_s), .v_last_s(v_last_s), .v_rdy_s(v_rdy_s),
    .vld_m(vld_m), .rdy_m(rdy_m), .sel_oh(sel_oh), .sel_idx(sel_idx), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_sel();
    if (m_locked) return m_owner;
    foreach (q[k]) if (v_vld_s[q[k]]) return q[k];
    return -1;
  endfunction

  function automatic logic [W-1:0] to_oh(input int s);
    logic [W-1:0] one = 1;
    return (s < 0) ? '0 : one << s;
  endfunction

  task automatic model_reset();
    q.delete();
    for (int c = 0; c < W; c++) begin q.push_back(c); wait_c[c] = 0; end
    m_locked = 0;
    m_owner  = 0;
  endtask

  task automatic model_advance();
    int s, mx;
    logic [W-1:0] oh;
    s  = exp_sel();
    oh = to_oh(s);
    if (rst) begin model_reset(); return; end
    for (int c = 0; c < W; c++) if (!v_vld_s[c]) wait_c[c] = 0;
    if (|(v_vld_s & oh) && rdy_m) begin
      if (!v_last_s[s]) begin
        m_locked = 1;
        m_owner  = s;
      end else begin
        m_locked = 0;
        foreach (q[k]) if (q[k] == s) begin q.delete(k); break; end
        q.push_back(s);
        mx = 0;
        for (int c = 0; c < W; c++) begin
          if (c == s) wait_c[c] = 0;
          else if (v_vld_s[c]) wait_c[c]++;
          if (wait_c[c] > mx) mx = wait_c[c];
        end
        chk("starve_bound", 32'(mx <= W - 1), 1);
      end
    end
  endtask

  task automatic step(input logic [W-1:0] vld, input logic [W-1:0] last,
                      input logic rdy, input logic r);
    int s;
    logic [W-1:0] oh;
    model_advance();
    @(posedge clk);
    #1;
    v_vld_s = vld; v_last_s = last; rdy_m = rdy; rst = r;
    #3;
    s  = exp_sel();
    oh = to_oh(s);
    chk("sel_oh",  32'(sel_oh),  32'(oh));
    chk("sel_idx", 32'(sel_idx), (s < 0) ? 0 : s);
    chk("vld_m",   32'(vld_m),   32'(|(vld & oh)));
    chk("v_rdy_s", 32'(v_rdy_s), 32'(oh & vld & {W{rdy}}));
    chk("locked",  32'(locked),  32'(m_locked));
    chk("rdy_onehot", 32'($countones(v_rdy_s) <= 1), 1);
  endtask

  initial begin
    model_reset();
    step('0, '0, 1'b0, 1'b1);
    step('0, '0, 1'b0, 1'b0);
    chk("reset_locked", 32'(locked), 0);
    chk("reset_sel", 32'(sel_oh), 0);

    // round robin over four requesters from reset order
    for (int i = 0; i < 4; i++) begin
      step(8'h0f, 8'hff, 1'b1, 1'b0);
      chk("rr_idx", 32'(sel_idx), i);
    end

    // stall: selection holds, no ready, no state change
    step('0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(8'h06, 8'hff, 1'b0, 1'b0);
      chk("stall_oh", 32'(sel_oh), 32'h2);
      chk("stall_rdy", 32'(v_rdy_s), 0);
    end
    step(8'h06, 8'hff, 1'b1, 1'b0);
    chk("stall_go", 32'(v_rdy_s), 32'h2);
    step(8'h06, 8'hff, 1'b1, 1'b0);
    chk("stall_next", 32'(sel_oh), 32'h4);

    // three-beat lock on ch2 against ch0/ch1
    step('0, '0, 1'b0, 1'b1);
    step(8'h04, 8'h00, 1'b1, 1'b0);
    step(8'h07, 8'h00, 1'b1, 1'b0);
    chk("lock_b2", 32'(locked), 1);
    chk("lock_b2_rdy", 32'(v_rdy_s), 32'h4);
    step(8'h07, 8'h04, 1'b1, 1'b0);
    chk("lock_b3_rdy", 32'(v_rdy_s), 32'h4);
    step(8'h03, 8'hff, 1'b1, 1'b0);
    chk("lock_after", 32'(locked), 0);
    chk("lock_after_oh", 32'(sel_oh), 32'h1);

    // owner drops valid while locked
    step('0, '0, 1'b0, 1'b1);
    step(8'h02, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(8'h08, 8'h00, 1'b1, 1'b0);
      chk("drop_vld", 32'(vld_m), 0);
      chk("drop_rdy", 32'(v_rdy_s), 0);
    end
    step(8'h0a, 8'h02, 1'b1, 1'b0);
    chk("resume_rdy", 32'(v_rdy_s), 32'h2);
    step(8'h08, 8'hff, 1'b1, 1'b0);
    chk("resume_ch3", 32'(v_rdy_s), 32'h8);

    // reset while locked on ch3
    step('0, '0, 1'b0, 1'b1);
    step(8'h08, 8'h00, 1'b1, 1'b0);
    step(8'h08, 8'h00, 1'b0, 1'b1);
    step(8'h0a, 8'hff, 1'b1, 1'b0);
    chk("rst_lock", 32'(locked), 0);
    chk("rst_grant", 32'(sel_idx), 1);

    for (int n = 0; n < 10000; n++)
      step(W'($urandom), W'($urandom), ($urandom_range(0, 3) != 0), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
